// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks and latches the result as saturating BCD.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int DIGITS      = 6
) (
  input  logic                  clk100M,
  input  logic                  clr,
  input  logic                  sig_in,
  output logic [4*DIGITS-1:0]   freq_bcd,
  output logic                  valid,
  output logic                  ovf,
  output logic                  gate
);

  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {ARM, MEASURE, LATCH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sync_q;
  logic                rise;
  logic [CW-1:0]       gcnt_q, gcnt_d;
  logic [4*DIGITS-1:0] work_q, work_d, work_inc;
  logic                wovf_q, wovf_d;
  logic [4*DIGITS-1:0] freq_q;
  logic                ovf_q, valid_q, gate_q;
  logic [DIGITS-1:0]   nine, carry;
  logic                all_nines;

  // sync_q[1] is the synchronized input, sync_q[2] its one-cycle-old copy
  assign rise = sync_q[1] & ~sync_q[2];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig      = work_q[4*gi +: 4];
      assign nine[gi] = (dig == 4'd9);
      if (gi == 0) begin : g_first
        assign carry[gi] = 1'b1;
      end else begin : g_rest
        assign carry[gi] = carry[gi-1] & nine[gi-1];
      end
      assign work_inc[4*gi +: 4] = !carry[gi] ? dig : (nine[gi] ? 4'd0 : dig + 4'd1);
    end
  endgenerate

  assign all_nines = &nine;

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    work_d  = work_q;
    wovf_d  = wovf_q;
    case (state_q)
      ARM: begin
        gcnt_d  = '0;
        work_d  = '0;
        wovf_d  = 1'b0;
        state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          // saturate at all nines instead of wrapping to zero
          if (all_nines) wovf_d = 1'b1;
          else           work_d = work_inc;
        end
        if (gcnt_q == LAST) state_d = LATCH;
        else                gcnt_d  = gcnt_q + CW'(1);
      end
      LATCH:   state_d = ARM;
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk100M or posedge clr) begin
    if (clr) begin
      state_q <= ARM;
      sync_q  <= '0;
      gcnt_q  <= '0;
      work_q  <= '0;
      wovf_q  <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], sig_in};
      gcnt_q  <= gcnt_d;
      work_q  <= work_d;
      wovf_q  <= wovf_d;
      if (state_q == LATCH) begin
        freq_q <= work_q;
        ovf_q  <= wovf_q;
      end
      valid_q <= (state_q == LATCH);
      gate_q  <= (state_d == MEASURE);
    end
  end

  assign freq_bcd = freq_q;
  assign ovf      = ovf_q;
  assign valid    = valid_q;
  assign gate     = gate_q;

endmodule
